// File: rtl/ula_if.sv
// Operand/result bundle for ula_param: request side (Start, A, B, Opcode)
// and registered result side (ResultadoULA, Done, Busy, flags).
interface ula_if #(
  parameter int W = 16
);
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   Opcode;
  logic [W-1:0] ResultadoULA;
  logic         Done;
  logic         Busy;
  logic         Zero;
  logic         Negative;
  logic         Carry;
  logic         Overflow;

  modport master (
    output Start, A, B, Opcode,
    input  ResultadoULA, Done, Busy,
    input  Zero, Negative, Carry, Overflow
  );

  modport slave (
    input  Start, A, B, Opcode,
    output ResultadoULA, Done, Busy,
    output Zero, Negative, Carry, Overflow
  );
endinterface

// File: rtl/ula_param.sv
// Registered W-bit ALU with Start/Done handshake, flags, full shifter
// and an iterative shift-add multiplier.
module ula_param #(
  parameter int W          = 16,
  parameter int SLT_SIGNED = 0,
  parameter int MUL_EN     = 1
) (
  input logic Clock,
  input logic Resetn,
  ula_if.slave bus
);
  localparam int L = $clog2(W);

  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SRA = 4'b1101;
  localparam logic [3:0] OP_MUL = 4'b1110;

  typedef enum logic {IDLE, MUL} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] res_q, res_d;
  logic         z_q, z_d;
  logic         n_q, n_d;
  logic         c_q, c_d;
  logic         v_q, v_d;
  logic         done_q, done_d;
  logic [W-1:0] mcand_q, mcand_d;
  logic [W-1:0] mplier_q, mplier_d;
  logic [W-1:0] acc_q, acc_d;
  logic [L-1:0] cnt_q, cnt_d;

  logic [W:0]   sum_w;
  logic [W:0]   dif_w;
  logic [L-1:0] shamt;
  logic         big_sh;
  logic         lt;
  logic         is_mul;
  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;
  logic [W-1:0] prod;

  always_comb begin
    sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
    dif_w  = {1'b0, bus.A} - {1'b0, bus.B};
    shamt  = bus.B[L-1:0];
    big_sh = |bus.B[W-1:L];
    if (SLT_SIGNED != 0) lt = $signed(bus.A) < $signed(bus.B);
    else                 lt = bus.A < bus.B;
    is_mul = (MUL_EN != 0) && (bus.Opcode == OP_MUL);

    alu_res = bus.B;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.Opcode)
      OP_ADD: begin
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (bus.A[W-1] == bus.B[W-1]) &&
                  (sum_w[W-1] != bus.A[W-1]);
      end
      OP_SUB: begin
        alu_res = dif_w[W-1:0];
        alu_c   = dif_w[W];
        alu_v   = (bus.A[W-1] != bus.B[W-1]) &&
                  (dif_w[W-1] != bus.A[W-1]);
      end
      OP_OR:  alu_res = bus.A | bus.B;
      OP_SLT: alu_res = {{(W-1){1'b0}}, lt};
      OP_SLL: alu_res = big_sh ? '0 : (bus.A << shamt);
      OP_SRL: alu_res = big_sh ? '0 : (bus.A >> shamt);
      OP_AND: alu_res = bus.A & bus.B;
      OP_XOR: alu_res = bus.A ^ bus.B;
      OP_SRA: alu_res = big_sh ? {W{bus.A[W-1]}}
                               : W'($signed(bus.A) >>> shamt);
      default: alu_res = bus.B;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod     = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (is_mul) begin
            mcand_d  = bus.A;
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            res_d  = alu_res;
            z_d    = (alu_res == '0);
            n_d    = alu_res[W-1];
            c_d    = alu_c;
            v_d    = alu_v;
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The final bit's partial sum goes straight to the result.
        if (cnt_q == L'(W-1)) begin
          res_d   = prod;
          z_d     = (prod == '0);
          n_d     = prod[W-1];
          c_d     = 1'b0;
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ResultadoULA = res_q;
  assign bus.Done         = done_q;
  assign bus.Busy         = (state_q == MUL);
  assign bus.Zero         = z_q;
  assign bus.Negative     = n_q;
  assign bus.Carry        = c_q;
  assign bus.Overflow     = v_q;
endmodule

// File: tb/tb_ula_param.sv
// Directed scoreboard bench for ula_param (W=16), with a second
// instance using signed slt.
module tb_ula_param;
  localparam int W = 16;

  localparam logic [3:0] ADD = 4'b0101;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] OR_ = 4'b0111;
  localparam logic [3:0] SLT = 4'b1000;
  localparam logic [3:0] SLL = 4'b1001;
  localparam logic [3:0] SRL = 4'b1010;
  localparam logic [3:0] AND_ = 4'b1011;
  localparam logic [3:0] XOR_ = 4'b1100;
  localparam logic [3:0] SRA = 4'b1101;
  localparam logic [3:0] MUL = 4'b1110;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   f;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  ula_if #(.W(W)) u0 ();
  ula_if #(.W(W)) u1 ();

  assign u0.Start  = start;
  assign u0.A      = a;
  assign u0.B      = b;
  assign u0.Opcode = op;
  assign u1.Start  = start;
  assign u1.A      = a;
  assign u1.B      = b;
  assign u1.Opcode = op;

  ula_param #(.W(W), .SLT_SIGNED(0), .MUL_EN(1)) dut0 (
    .Clock (clk),
    .Resetn(rst_n),
    .bus   (u0.slave)
  );

  ula_param #(.W(W), .SLT_SIGNED(1), .MUL_EN(1)) dut1 (
    .Clock (clk),
    .Resetn(rst_n),
    .bus   (u1.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic [W-1:0] r,
                       input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.res = r;
    e.f   = f;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] flags0();
    return {u0.Zero, u0.Negative, u0.Carry, u0.Overflow};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && u0.Done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", u0.Done, 0);
      end else begin
        e = sb.pop_front();
        chk("result", u0.ResultadoULA, e.res);
        chk("flags_zncv", flags0(), e.f);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", u0.ResultadoULA, 0);
    chk("rst_flags", flags0(), 0);
    chk("rst_done", u0.Done, 0);
    chk("rst_busy", u0.Busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    @(posedge clk); #1;
    chk("add_latency_done", u0.Done, 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_drops", u0.Done, 0);

    issue(SUB, 16'h0005, 16'h0007, 16'hFFFE, 4'b0110);
    issue(ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    issue(SLL, 16'h0003, 16'h0001, 16'h0006, 4'b0000);
    issue(SRL, 16'h0006, 16'h0001, 16'h0003, 4'b0000);
    issue(SRA, 16'h8000, 16'h0004, 16'hF800, 4'b0100);
    issue(SLL, 16'h0001, 16'h0010, 16'h0000, 4'b1000);
    issue(SRA, 16'h8000, 16'h0020, 16'hFFFF, 4'b0100);
    issue(SRL, 16'h8000, 16'h0011, 16'h0000, 4'b1000);
    issue(SLT, 16'hFFFF, 16'h0001, 16'h0000, 4'b1000);
    @(posedge clk); #1;
    chk("slt_signed_result", u1.ResultadoULA, 1);
    chk("slt_signed_done", u1.Done, 1);
    issue(OR_, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
    issue(AND_, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100);
    issue(XOR_, 16'hAAAA, 16'hFFFF, 16'h5555, 4'b0000);
    issue(4'b0000, 16'h0001, 16'h1234, 16'h1234, 4'b0000);
    issue(4'b1111, 16'h0001, 16'h8001, 16'h8001, 4'b0100);
    issue(SUB, 16'h0007, 16'h0005, 16'h0002, 4'b0000);
    issue(SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hold_result", u0.ResultadoULA, 16'h7FFF);
    chk("hold_flags", flags0(), 4'b0001);
    chk("hold_done", u0.Done, 0);

    issue(MUL, 16'd300, 16'd300, 16'h5F90, 4'b0000);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("mul_busy", u0.Busy, 1);
      chk("mul_no_done", u0.Done, 0);
      start = 1'b0;
      if (j == 5) begin
        start = 1'b1;
        op    = ADD;
        a     = 16'h0001;
        b     = 16'h0001;
      end
      if (j == 15) begin
        start = 1'b1;
        op    = ADD;
        a     = 16'h0002;
        b     = 16'h0002;
        e.res = 16'h0004;
        e.f   = 4'b0000;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    chk("mul_end_busy", u0.Busy, 0);
    chk("mul_end_done", u0.Done, 1);
    @(negedge clk);
    start = 1'b0;
    chk("add_after_mul_done", u0.Done, 1);
    @(negedge clk);
    chk("post_mul_done", u0.Done, 0);
    chk("post_mul_hold", u0.ResultadoULA, 16'h0004);

    @(negedge clk);
    start = 1'b1;
    op    = MUL;
    a     = 16'd300;
    b     = 16'd300;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_busy_before", u0.Busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", u0.ResultadoULA, 0);
    chk("abort_flags", flags0(), 0);
    chk("abort_busy", u0.Busy, 0);
    chk("abort_done", u0.Done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("abort_no_done", u0.Done, 0);
    end
    chk("abort_idle_busy", u0.Busy, 0);

    issue(ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
